// File: rtl/ulpb_node.sv
// ulpb_node: ULPB ring member-node bus engine.
// Requests the ring by pulling data low, arbitrates on the first bus-clock
// rise, then shifts a 40-bit message (8-bit address + 32-bit payload)
// out on bus-clock falls or in on bus-clock rises. Ring data is forwarded
// downstream whenever this node is not the transmitter.
//
// Ports:
//   CLK_IN    system clock (ring signals are oversampled on it)
//   RESET     synchronous active-high reset
//   BUS_CLK   ring clock from bus control (asynchronous)
//   BUS_DIN   ring data from upstream (asynchronous)
//   BUS_DOUT  ring data to downstream
//   TX_REQ    level request to transmit (sampled in IDLE only)
//   TX_ADDR   destination address, latched at acceptance
//   TX_DATA   payload, latched at acceptance
//   TX_ACK    one-cycle pulse on completed transmit
//   TX_FAIL   one-cycle pulse on lost arbitration / aborted transmit
//   RX_DATA   last accepted payload
//   RX_VALID  one-cycle pulse when RX_DATA updates
//   BUSY      high in every state except IDLE
//
// Build option: define ULPB_BROADCAST_EN to also accept address 8'hFF.

module ulpb_node #(
    parameter logic [7:0]  NODE_ADDR    = 8'hA5,
    parameter int unsigned IDLE_TIMEOUT = 40
) (
    input  logic        CLK_IN,
    input  logic        RESET,
    input  logic        BUS_CLK,
    input  logic        BUS_DIN,
    output logic        BUS_DOUT,
    input  logic        TX_REQ,
    input  logic [7:0]  TX_ADDR,
    input  logic [31:0] TX_DATA,
    output logic        TX_ACK,
    output logic        TX_FAIL,
    output logic [31:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_TX,
        S_TX_END,
        S_RX,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic din_s1_q, din_s2_q;

    logic [39:0]   sh_q, sh_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          slot_q, slot_d;
    logic          done_q, done_d;
    logic          dout_q, dout_d;
    logic [31:0]   rxd_q, rxd_d;
    logic          rxv_q, rxv_d;
    logic          ack_q, ack_d;
    logic          fail_q, fail_d;

    logic rise, fall, timeout, addr_ok;

    assign rise = clk_s2_q & ~clk_prev_q;
    assign fall = ~clk_s2_q & clk_prev_q;
    assign timeout = (state_q != S_IDLE)
                  && (to_q == TO_MAX);

    // Address field of the word completing on this rise.
`ifdef ULPB_BROADCAST_EN
    assign addr_ok = (sh_q[38:31] == NODE_ADDR)
                  || (sh_q[38:31] == 8'hFF);
`else
    assign addr_ok = (sh_q[38:31] == NODE_ADDR);
`endif

    // Synchronizers, edge history and state register.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            din_s1_q   <= 1'b1;
            din_s2_q   <= 1'b1;
            state_q    <= S_IDLE;
        end else begin
            clk_s1_q   <= BUS_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            din_s1_q   <= BUS_DIN;
            din_s2_q   <= din_s1_q;
            state_q    <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (TX_REQ)
                        state_d = S_REQ;
                    else if (!din_s2_q)
                        state_d = S_RX;
                end
                S_REQ: begin
                    if (rise)
                        state_d = din_s2_q ? S_TX : S_RX;
                end
                S_TX: begin
                    if (fall && cnt_q == 6'd39)
                        state_d = S_TX_END;
                end
                S_TX_END: begin
                    // Leave after the end-pattern 0 was sampled.
                    if (rise && cnt_q == 6'd42)
                        state_d = S_WAIT;
                end
                S_RX: begin
                    if (rise && !slot_q && cnt_q == 6'd39)
                        state_d = S_WAIT;
                end
                S_WAIT: state_d = S_WAIT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        slot_d = slot_q;
        done_d = done_q;
        dout_d = dout_q;
        rxd_d  = rxd_q;
        rxv_d  = 1'b0;
        ack_d  = 1'b0;
        fail_d = 1'b0;
        BUSY   = (state_q != S_IDLE);

        // IDLE holds the counter at zero so a new
        // transaction starts with a full window.
        if (state_q == S_IDLE || rise || fall)
            to_d = '0;
        else if (to_q != TO_MAX)
            to_d = to_q + TW'(1);
        else
            to_d = to_q;

        if (timeout) begin
            fail_d = (state_q == S_TX)
                  || (state_q == S_TX_END);
            ack_d  = (state_q == S_WAIT) && done_q;
            done_d = 1'b0;
            cnt_d  = '0;
            dout_d = din_s2_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    done_d = 1'b0;
                    if (TX_REQ) begin
                        sh_d   = {TX_ADDR, TX_DATA};
                        dout_d = 1'b0;
                    end else begin
                        dout_d = din_s2_q;
                        slot_d = 1'b1;
                    end
                end
                S_REQ: begin
                    dout_d = 1'b0;
                    if (rise && !din_s2_q) begin
                        // Upstream won; its arbitration
                        // slot is consumed here.
                        fail_d = 1'b1;
                        dout_d = din_s2_q;
                        slot_d = 1'b0;
                        cnt_d  = '0;
                    end
                end
                S_TX: begin
                    if (fall) begin
                        dout_d = sh_q[39];
                        sh_d   = {sh_q[38:0], 1'b0};
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
                S_TX_END: begin
                    if (fall && cnt_q == 6'd40) begin
                        dout_d = 1'b1;
                        cnt_d  = cnt_q + 6'd1;
                    end else if (fall && cnt_q == 6'd41) begin
                        dout_d = 1'b0;
                        cnt_d  = cnt_q + 6'd1;
                    end
                    if (rise && cnt_q == 6'd42)
                        done_d = 1'b1;
                end
                S_RX: begin
                    dout_d = din_s2_q;
                    if (rise && slot_q) begin
                        slot_d = 1'b0;
                    end else if (rise) begin
                        sh_d  = {sh_q[38:0], din_s2_q};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd39 && addr_ok) begin
                            rxd_d = {sh_q[30:0], din_s2_q};
                            rxv_d = 1'b1;
                        end
                    end
                end
                S_WAIT: dout_d = din_s2_q;
                default: dout_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            to_q   <= '0;
            slot_q <= 1'b0;
            done_q <= 1'b0;
            dout_q <= 1'b1;
            rxd_q  <= '0;
            rxv_q  <= 1'b0;
            ack_q  <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            to_q   <= to_d;
            slot_q <= slot_d;
            done_q <= done_d;
            dout_q <= dout_d;
            rxd_q  <= rxd_d;
            rxv_q  <= rxv_d;
            ack_q  <= ack_d;
            fail_q <= fail_d;
        end
    end

    assign BUS_DOUT = dout_q;
    assign RX_DATA  = rxd_q;
    assign RX_VALID = rxv_q;
    assign TX_ACK   = ack_q;
    assign TX_FAIL  = fail_q;

endmodule
